sseg_display_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display among N_REQ requesters (operand entry, result, status, ...).

---
 rtl/sseg_display_arbiter_pkg.sv | 17 +
 rtl/sseg_display_arbiter_rr_pick.sv | 37 +++
 rtl/sseg_display_arbiter.sv | 146 ++++++++++++++
 tb/tb_sseg_display_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// State encodings, the default idle digit word and pointer-width helper.
package sseg_display_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    localparam logic [15:0] DEFAULT_IDLE_PATTERN = 16'h0000;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sseg_display_arbiter_rr_pick.sv
// Combinational cyclic priority encoder: first set mask bit at or after start,
// wrapping past N_REQ-1 back to 0. start is assumed to be below N_REQ.
module sseg_display_arbiter_rr_pick #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] mask,
    input  logic [PTR_W-1:0] start,
    output logic             valid,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        valid  = 1'b0;
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (int'(start) + off >= N_REQ) begin
                cand = PTR_W'(int'(start) + off - N_REQ);
            end else begin
                cand = PTR_W'(int'(start) + off);
            end
            if (mask[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                onehot      = '0;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner arbitration of the 4-digit seven-segment display with a minimum hold.
// Optional high-priority preemption by requester 0 when SSEG_ARB_PREEMPT_EN is defined.
module sseg_display_arbiter
    import sseg_display_arbiter_pkg::*;
#(
    parameter int          N_REQ        = 3,
    parameter int          MIN_HOLD     = 50_000_000,
    parameter int          CNT_W        = 26,
    parameter logic [15:0] IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   data_in,
    input  logic [N_REQ-1:0]      dp_in,
    output logic [N_REQ-1:0]      grant,
    output logic [15:0]           D,
    output logic                  dp_check,
    output logic                  busy
);

    localparam int PTR_W = ptr_width(N_REQ);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner_idx;

    logic [15:0]      words [N_REQ];
    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] ptr_after_pick;
    logic             hold_done;
    logic             expired;
    logic             owner_req;
    logic             preempt;
    logic             owner0_locked;
    logic             do_switch;
    logic             do_release;

    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = data_in[16*g +: 16];
    end

    // In IDLE grant is zero, so one masked picker serves both IDLE and OWN.
    sseg_display_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask   (req & ~grant),
        .start  (rr_ptr),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    assign ptr_after_pick = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign hold_done      = (hold_cnt == CNT_W'(MIN_HOLD - 1));
    assign owner_req      = req[owner_idx];

`ifdef SSEG_ARB_PREEMPT_EN
    logic req0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            req0_q <= 1'b0;
        end else begin
            req0_q <= req[0];
        end
    end

    assign preempt       = req[0] & ~req0_q;
    assign owner0_locked = grant[0] & req[0];
`else
    assign preempt       = 1'b0;
    assign owner0_locked = 1'b0;
`endif

    // The last HOLD cycle is judged like OWN, so a contended grant lasts exactly MIN_HOLD cycles.
    assign expired = (state == ST_OWN) || ((state == ST_HOLD) && hold_done);

    always_comb begin
        do_switch  = 1'b0;
        do_release = 1'b0;
        if (state == ST_IDLE) begin
            do_switch = pick_valid;
        end else if (expired) begin
            if (pick_valid && !owner0_locked) begin
                do_switch = 1'b1;
            end else if (!owner_req) begin
                do_release = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            rr_ptr    <= '0;
            owner_idx <= '0;
            grant     <= '0;
            D         <= IDLE_PATTERN;
            dp_check  <= 1'b0;
            busy      <= 1'b0;
        end else if (preempt) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            owner_idx <= '0;
            grant     <= N_REQ'(1);
            D         <= words[0];
            dp_check  <= dp_in[0];
            busy      <= 1'b1;
        end else if (do_switch) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            rr_ptr    <= ptr_after_pick;
            owner_idx <= pick_idx;
            grant     <= pick_onehot;
            D         <= words[pick_idx];
            dp_check  <= dp_in[pick_idx];
            busy      <= 1'b1;
        end else if (do_release) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            grant     <= '0;
            D         <= IDLE_PATTERN;
            dp_check  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_done) begin
                    state <= ST_OWN;
                end
            end
            // Live updates only while the owner still asserts req; otherwise the word freezes.
            if (busy && owner_req) begin
                D        <= words[owner_idx];
                dp_check <= dp_in[owner_idx];
            end
        end
    end

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Self-checking bench for sseg_display_arbiter (N_REQ=3, MIN_HOLD=4) with an ownership-age reference model.
module tb_sseg_display_arbiter;

    localparam int N        = 3;
    localparam int MIN_HOLD = 4;
`ifdef SSEG_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [15:0]   data [N];
    logic [16*N-1:0] data_in;
    logic [N-1:0]  dp_in;
    logic [N-1:0]  grant;
    logic [15:0]   D;
    logic          dp_check;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // Reference model: owner (-1 = nobody), cycles owned so far, rotation pointer.
    int          m_owner;
    int          m_age;
    int          m_ptr;
    logic [15:0] m_D;
    logic        m_dp;
    bit          m_req0_prev;

    assign data_in = {data[2], data[1], data[0]};

    sseg_display_arbiter #(
        .N_REQ        (N),
        .MIN_HOLD     (MIN_HOLD),
        .CNT_W        (3),
        .IDLE_PATTERN (16'h0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .dp_in    (dp_in),
        .grant    (grant),
        .D        (D),
        .dp_check (dp_check),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [N-1:0] m_grant();
        return (m_owner < 0) ? '0 : (3'b001 << m_owner);
    endfunction

    function automatic int first_from(input logic [N-1:0] m, input int p);
        for (int off = 0; off < N; off++) begin
            if (((m >> ((p + off) % N)) & 3'b001) != 3'b000) return (p + off) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner     = -1;
        m_age       = 0;
        m_ptr       = 0;
        m_D         = 16'h0000;
        m_dp        = 1'b0;
        m_req0_prev = 1'b0;
    endtask

    task automatic grant_to(input int p, input bit advance);
        logic [1:0] pi;
        pi      = p[1:0];
        m_owner = p;
        m_age   = 1;
        m_D     = data[pi];
        m_dp    = dp_in[pi];
        if (advance) m_ptr = (p + 1) % N;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        logic [1:0]   oi;
        bit           rise0;
        int           p;
        rise0       = PREEMPT && req[0] && !m_req0_prev;
        m_req0_prev = req[0];
        if (rise0) begin
            grant_to(0, 1'b0);
        end else if (m_owner < 0) begin
            p = first_from(req, m_ptr);
            if (p >= 0) grant_to(p, 1'b1);
        end else begin
            oi     = m_owner[1:0];
            others = req & ~m_grant();
            if (m_age >= MIN_HOLD && others != 0 && !(PREEMPT && m_owner == 0 && req[0])) begin
                grant_to(first_from(others, m_ptr), 1'b1);
            end else if (m_age >= MIN_HOLD && !req[oi]) begin
                m_owner = -1;
                m_D     = 16'h0000;
                m_dp    = 1'b0;
            end else begin
                m_age++;
                if (req[oi]) begin
                    m_D  = data[oi];
                    m_dp = dp_in[oi];
                end
            end
        end
    endtask

    // Advance the model with the inputs as driven, then let the DUT take the same edge.
    task automatic tick();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (grant !== 3'b000 || D !== 16'h0000 || dp_check !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset k=%0d got grant=%b D=%h dp=%b busy=%b exp 000/0000/0/0", k, grant, D, dp_check, busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        data[1] = 16'h1234;
        dp_in   = 3'b010;
        req     = 3'b010;
        tick();
        checks++;
        if (grant !== 3'b010 || D !== 16'h1234 || dp_check !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got grant=%b D=%h dp=%b busy=%b exp 010/1234/1/1", grant, D, dp_check, busy);
        end
        req = '0;
        n   = 1;
        for (int k = 0; k < 20 && grant !== 3'b000; k++) begin
            tick();
            if (grant !== 3'b000) n++;
        end
        checks++;
        if (n != MIN_HOLD) begin
            errors++;
            $display("FAIL single_hold_len got=%0d exp=%0d", n, MIN_HOLD);
        end
        checks++;
        if (D !== 16'h0000 || dp_check !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got D=%h dp=%b busy=%b exp 0000/0/0", D, dp_check, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [15:0]  exp_d;
        do_reset();
        data[0] = 16'h0A0A;
        data[1] = 16'h1B1B;
        data[2] = 16'h2C2C;
        dp_in   = 3'b101;
        req     = 3'b111;
        for (int k = 0; k < 24; k++) begin
            tick();
`ifdef SSEG_ARB_PREEMPT_EN
            exp_g = m_grant();
            exp_d = m_D;
`else
            exp_g = 3'b001 << ((k / MIN_HOLD) % N);
            exp_d = data[2'((k / MIN_HOLD) % N)];
`endif
            checks++;
            if (grant !== exp_g || D !== exp_d) begin
                errors++;
                $display("FAIL rr k=%0d got grant=%b D=%h exp grant=%b D=%h", k, grant, D, exp_g, exp_d);
            end
        end
    endtask

    task automatic test_hold_freeze();
        do_reset();
        data[1] = 16'hAAAA;
        dp_in   = 3'b010;
        req     = 3'b010;
        tick();
        req     = 3'b000;
        data[1] = 16'hBBBB;
        dp_in   = 3'b000;
        for (int k = 0; k < MIN_HOLD - 1; k++) begin
            tick();
            checks++;
            if (grant !== 3'b010 || D !== 16'hAAAA || dp_check !== 1'b1) begin
                errors++;
                $display("FAIL freeze k=%0d got grant=%b D=%h dp=%b exp 010/aaaa/1", k, grant, D, dp_check);
            end
        end
        tick();
        checks++;
        if (grant !== 3'b000 || D !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_release got grant=%b D=%h busy=%b exp 000/0000/0", grant, D, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req = 3'b010;
        tick();
        tick();
        req = 3'b011;
        rst = 1'b1;
        tick();
        checks++;
        if (grant !== 3'b000 || D !== 16'h0000 || dp_check !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset got grant=%b D=%h dp=%b busy=%b exp 000/0000/0/0", grant, D, dp_check, busy);
        end
        rst     = 1'b0;
        data[0] = 16'h5555;
        dp_in   = 3'b001;
        tick();
        checks++;
        if (grant !== 3'b001 || D !== 16'h5555 || dp_check !== 1'b1) begin
            errors++;
            $display("FAIL midreset_regrant got grant=%b D=%h dp=%b exp 001/5555/1", grant, D, dp_check);
        end
    endtask

    task automatic test_preempt();
        do_reset();
        data[0] = 16'hEEEE;
        data[2] = 16'h2222;
        dp_in   = 3'b000;
        req     = 3'b100;
        tick();
        tick();
        req = 3'b101;
        tick();
`ifdef SSEG_ARB_PREEMPT_EN
        checks++;
        if (grant !== 3'b001 || D !== 16'hEEEE) begin
            errors++;
            $display("FAIL preempt got grant=%b D=%h exp 001/eeee", grant, D);
        end
`else
        checks++;
        if (grant !== 3'b100 || D !== 16'h2222) begin
            errors++;
            $display("FAIL no_preempt got grant=%b D=%h exp 100/2222", grant, D);
        end
        tick();
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL no_preempt_hold got grant=%b exp 100", grant);
        end
        tick();
        checks++;
        if (grant !== 3'b001 || D !== 16'hEEEE) begin
            errors++;
            $display("FAIL no_preempt_switch got grant=%b D=%h exp 001/eeee", grant, D);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) data[$urandom_range(0, 2)] = 16'($urandom_range(0, 65535));
            dp_in = 3'($urandom_range(0, 7));
            tick();
            checks++;
            if (grant !== m_grant() || busy !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL rand_grant k=%0d got grant=%b busy=%b exp grant=%b busy=%b", k, grant, busy, m_grant(), m_owner >= 0);
            end
            checks++;
            if (D !== m_D || dp_check !== m_dp) begin
                errors++;
                $display("FAIL rand_data k=%0d got D=%h dp=%b exp D=%h dp=%b", k, D, dp_check, m_D, m_dp);
            end
            checks++;
            if ($countones(grant) > 1) begin
                errors++;
                $display("FAIL rand_onehot k=%0d got grant=%b exp at most one bit", k, grant);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        dp_in = '0;
        for (int i = 0; i < N; i++) data[i] = 16'h0000;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_hold_freeze();
        test_reset_mid_hold();
        test_preempt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
